// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences Zicsr read/modify/write accesses to the CSR file over valid/ready handshakes
module csr_access_ctrl #(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_op,
  input  logic              req_use_imm,
  input  logic [REG_W-1:0]  req_rs1,
  input  logic [4:0]        req_zimm,
  input  logic              req_src_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [REG_W-1:0]  resp_rdata,
  output logic              resp_illegal,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              csr_wen,
  output logic [REG_W-1:0]  csr_wdata,
  input  logic [REG_W-1:0]  csr_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] op_q;
  logic [REG_W-1:0] opnd_q, old_q;
  logic src_zero_q, illegal_q, impl, wr_req, illegal;
  assign impl = addr_q == 12'h301 || addr_q == 12'hF11 || addr_q == 12'hF12 ||
                addr_q == 12'hB00 || (addr_q >= 12'hB02 && addr_q <= 12'hB0A) ||
                addr_q == 12'hB80 || (addr_q >= 12'hB82 && addr_q <= 12'hB8A);
  assign wr_req = op_q == 2'b01 || !src_zero_q;
  // top two address bits set marks the read-only CSR space
  assign illegal = !impl || op_q == 2'b00 || (wr_req && &addr_q[ADDR_W-1 -: 2]);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = req_valid ? READ : IDLE;
      READ:  state_nx = (!illegal && wr_req) ? WRITE : RESP;
      WRITE: state_nx = RESP;
      RESP:  state_nx = resp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      op_q       <= '0;
      opnd_q     <= '0;
      src_zero_q <= 1'b0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        addr_q     <= req_addr;
        op_q       <= req_op;
        opnd_q     <= req_use_imm ? {{(REG_W-5){1'b0}}, req_zimm} : req_rs1;
        src_zero_q <= req_src_zero;
      end
      if (state == READ) begin
        old_q     <= illegal ? '0 : csr_rdata;
        illegal_q <= illegal;
      end
    end
  end
  assign req_ready    = state == IDLE;
  assign resp_valid   = state == RESP;
  assign resp_rdata   = resp_valid ? old_q : '0;
  assign resp_illegal = resp_valid && illegal_q;
  assign csr_wen      = state == WRITE;
  assign csr_addr     = (state == READ || state == WRITE) ? addr_q : '0;
  assign csr_wdata    = !csr_wen ? '0 :
                        op_q == 2'b01 ? opnd_q :
                        op_q == 2'b10 ? (old_q | opnd_q) : (old_q & ~opnd_q);
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed self-checking bench for csr_access_ctrl
module tb_csr_access_ctrl;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_use_imm = 1'b0, req_src_zero = 1'b0;
  logic [11:0] req_addr = '0, csr_addr;
  logic [1:0] req_op = '0;
  logic [31:0] req_rs1 = '0, resp_rdata, csr_wdata, csr_rdata, csr_val = '0;
  logic [4:0] req_zimm = '0;
  logic resp_valid, resp_ready = 1'b0, resp_illegal, csr_wen;
  int checks = 0, errors = 0, wen_total = 0;
  logic [31:0] last_wdata = '0;
  logic [11:0] last_waddr = '0;

  always #5 clock = ~clock;
  assign csr_rdata = csr_val;

  csr_access_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
    .req_use_imm(req_use_imm), .req_rs1(req_rs1), .req_zimm(req_zimm), .req_src_zero(req_src_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  always @(posedge clock) if (csr_wen) begin
    wen_total  = wen_total + 1;
    last_wdata = csr_wdata;
    last_waddr = csr_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [11:0] a, input logic [1:0] op,
                        input logic imm, input logic [31:0] rs1, input logic [4:0] zimm,
                        input logic sz, input logic [31:0] cval, input int exp_lat,
                        input logic exp_ill, input logic [31:0] exp_rd, input int exp_wen,
                        input logic [31:0] exp_wd, input int bp);
    int w0, lat;
    @(negedge clock);
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    csr_val = cval; req_addr = a; req_op = op; req_use_imm = imm;
    req_rs1 = rs1; req_zimm = zimm; req_src_zero = sz; req_valid = 1'b1;
    w0 = wen_total;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!resp_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_ill"}, {31'b0, resp_illegal}, {31'b0, exp_ill});
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      chk({tag, "_bp_valid"}, {31'b0, resp_valid}, 32'd1);
      chk({tag, "_bp_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_bp_ill"}, {31'b0, resp_illegal}, {31'b0, exp_ill});
      chk({tag, "_bp_rdy"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    chk({tag, "_done_rdy"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_done_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_wen_cnt"}, wen_total - w0, exp_wen);
    if (exp_wen > 0) begin
      chk({tag, "_wdata"}, last_wdata, exp_wd);
      chk({tag, "_waddr"}, {20'b0, last_waddr}, {20'b0, a});
    end
  endtask

  initial begin
    int w0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_ill", {31'b0, resp_illegal}, 32'd0);
    chk("rst_csr_wen", {31'b0, csr_wen}, 32'd0);
    chk("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    //      tag        addr     op    imm   rs1           zimm   sz    cval          lat ill   rdata         wen wdata         bp
    do_req("rs_x0",    12'h301, 2'b10, 1'b0, 32'hFFFF_FFFF, 5'd0,  1'b1, 32'h4000_0010, 2, 1'b0, 32'h4000_0010, 0, 32'h0,        0);
    do_req("rw_f11",   12'hF11, 2'b01, 1'b0, 32'h1234_5678, 5'd0,  1'b0, 32'h0000_0555, 2, 1'b1, 32'h0,        0, 32'h0,        0);
    do_req("rci_b00",  12'hB00, 2'b11, 1'b1, 32'h0,         5'd5,  1'b0, 32'h0000_000F, 3, 1'b0, 32'h0000_000F, 1, 32'h0000_000A, 5);
    do_req("unimpl",   12'h7C0, 2'b01, 1'b0, 32'h1,         5'd0,  1'b0, 32'h0000_0077, 2, 1'b1, 32'h0,        0, 32'h0,        0);
    do_req("op00",     12'hB00, 2'b00, 1'b0, 32'h1,         5'd0,  1'b0, 32'h0000_0077, 2, 1'b1, 32'h0,        0, 32'h0,        0);
    do_req("rs_301",   12'h301, 2'b10, 1'b0, 32'h0000_0100, 5'd0,  1'b0, 32'h4000_0010, 3, 1'b0, 32'h4000_0010, 1, 32'h4000_0110, 0);
    do_req("rw_b8a",   12'hB8A, 2'b01, 1'b0, 32'h0000_DEAD, 5'd0,  1'b0, 32'h0000_0007, 3, 1'b0, 32'h0000_0007, 1, 32'h0000_DEAD, 0);
    do_req("gap_b81",  12'hB81, 2'b10, 1'b0, 32'h0,         5'd0,  1'b1, 32'h0000_0099, 2, 1'b1, 32'h0,        0, 32'h0,        0);
    do_req("rd_f12",   12'hF12, 2'b10, 1'b1, 32'h0,         5'd0,  1'b1, 32'h0000_1234, 2, 1'b0, 32'h0000_1234, 0, 32'h0,        0);
    do_req("rsi_f11",  12'hF11, 2'b10, 1'b1, 32'h0,         5'd3,  1'b0, 32'h0000_0001, 2, 1'b1, 32'h0,        0, 32'h0,        0);
    do_req("rwi_b02",  12'hB02, 2'b01, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'hAAAA_AAAA, 3, 1'b0, 32'hAAAA_AAAA, 1, 32'h0000_001F, 2);
    @(negedge clock);
    csr_val = 32'h0000_0001; req_addr = 12'h301; req_op = 2'b01; req_use_imm = 1'b0;
    req_rs1 = 32'h0000_0055; req_src_zero = 1'b0; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    w0 = wen_total;
    @(negedge clock);
    @(negedge clock);
    chk("mid_write_wen", {31'b0, csr_wen}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_wen", {31'b0, csr_wen}, 32'd0);
    chk("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_rdy", {31'b0, req_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_mid_lost_wr", wen_total - w0, 32'd0);
    chk("rst_mid_idle_valid", {31'b0, resp_valid}, 32'd0);
    do_req("post_rst", 12'hB80, 2'b10, 1'b0, 32'h0,         5'd0,  1'b1, 32'h0000_0042, 2, 1'b0, 32'h0000_0042, 0, 32'h0,        0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
